sram_wb_ctrl: RTL and testbench

- Wishbone B4 classic slave that fronts the 2048x32 single-port SRAM macro (sram_2048x32) and drives its access pins directly.
- Converts 32-bit Wishbone reads and writes, with 4-bit byte selects, into SRAM EN/R_WB/AD/BEN/DI cycles.
- Holds the macro's test and scan controls inactive.
- Optional post-reset clear engine writes every word before the bus is serviced.

---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_clear_seq.sv | 48 ++++
 rtl/sram_wb_ctrl.sv | 136 +++++++++++++
 tb/tb_sram_wb_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Purpose : shared types, sizes and helpers for the Wishbone-to-SRAM controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_e FSM encoding, SRAM geometry constants, sel_to_ben byte-select expander.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    localparam int SRAM_WORDS = 2048;
    localparam int SRAM_AW    = 11;
    localparam int SRAM_DW    = 32;

    // Expand a 4-bit Wishbone byte select into the macro's per-bit write mask.
    function automatic logic [SRAM_DW-1:0] sel_to_ben(input logic [3:0] sel);
        logic [SRAM_DW-1:0] ben;
        ben = '0;
        for (int k = 0; k < 4; k++) begin
            ben[8*k +: 8] = {8{sel[k]}};
        end
        return ben;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Purpose : address sequencer for the post-reset clear sweep (one word per cycle).
// Latency : addr_o valid combinationally from the counter; done_o asserts while the last word is presented.
// Backpr. : none; advances every cycle while run_i is high, stops at the last word.
// Ports   : clk_i, rst_n_i (sync, active-low), run_i in; en_o, addr_o, done_o out.
module sram_clear_seq
    import sram_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               run_i,
    output logic               en_o,
    output logic [SRAM_AW-1:0] addr_o,
    output logic               done_o
);

    localparam logic [SRAM_AW-1:0] LAST_ADDR = SRAM_AW'(SRAM_WORDS - 1);

    logic [SRAM_AW-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (run_i && !done_q) begin
            if (cnt_q == LAST_ADDR) begin
                // Saturate instead of wrapping so a late run_i can never re-sweep.
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign en_o   = run_i && !done_q;
    assign addr_o = cnt_q;
    assign done_o = en_o && (cnt_q == LAST_ADDR);

endmodule

// File: rtl/sram_wb_ctrl.sv
// Purpose : Wishbone B4 classic slave driving a 2048x32 single-port SRAM macro, with optional clear sweep.
// Latency : ack one cycle after a request is accepted; one access per two cycles at best.
// Backpr. : requests stall (no ack) during the clear sweep; out-of-window requests are never acked.
// Ports   : wbs_* Wishbone slave, ready_o sweep-done flag, ram_* macro pins (ram_tst tied to 0).
module sram_wb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] CLEAR_VALUE    = 32'h0000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                ready_o,
    output logic                ram_en,
    output logic                ram_r_wb,
    output logic [SRAM_AW-1:0]  ram_ad,
    output logic [SRAM_DW-1:0]  ram_ben,
    output logic [SRAM_DW-1:0]  ram_di,
    input  logic [SRAM_DW-1:0]  ram_do,
    output logic [4:0]          ram_tst
);

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                rd_q, rd_d;
    logic [31:0]         dat_q, dat_d;

    logic                clr_en;
    logic [SRAM_AW-1:0]  clr_addr;
    logic                clr_done;
    logic                hit;

    // Byte-offset bits are deliberately ignored: accesses are word-aligned.
    logic [1:0]          unused_adr_lsb;
    assign unused_adr_lsb = wbs_adr_i[1:0];

    sram_clear_seq u_clear_seq (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .run_i   (state_q == ST_CLEAR),
        .en_o    (clr_en),
        .addr_o  (clr_addr),
        .done_o  (clr_done)
    );

    assign hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:13] == BASE_ADDR[31:13]);

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        rd_d      = rd_q;
        dat_d     = dat_q;
        ram_en    = 1'b0;
        ram_r_wb  = 1'b1;
        ram_ad    = wbs_adr_i[12:2];
        ram_ben   = '0;
        ram_di    = wbs_dat_i;
        wbs_ack_o = 1'b0;
        wbs_dat_o = dat_q;

        unique case (state_q)
            ST_CLEAR: begin
                ram_en   = clr_en;
                ram_r_wb = 1'b0;
                ram_ad   = clr_addr;
                ram_ben  = '1;
                ram_di   = CLEAR_VALUE;
                if (clr_done) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                ready_d = 1'b1;
                if (hit) begin
                    // Macro pins are driven straight from the bus so the
                    // access completes on the accepting edge.
                    ram_en   = 1'b1;
                    ram_r_wb = ~wbs_we_i;
                    ram_ben  = wbs_we_i ? sel_to_ben(wbs_sel_i) : '0;
                    rd_d     = ~wbs_we_i;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                wbs_ack_o = 1'b1;
                // Read data is only valid this cycle, so pass it through
                // and keep a copy to hold after the ack.
                if (rd_q) begin
                    wbs_dat_o = ram_do;
                    dat_d     = ram_do;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep the macro quiet while reset is held, whatever the state.
        if (!wb_rst_n_i) begin
            ram_en   = 1'b0;
            ram_r_wb = 1'b1;
            ram_ben  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= RESET_STATE;
            ready_q <= 1'b0;
            rd_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            dat_q   <= dat_d;
        end
    end

    assign ready_o = ready_q;
    assign ram_tst = 5'b0;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Purpose : self-checking bench for sram_wb_ctrl with a behavioural SRAM macro model.
// Latency : n/a.
// Backpr. : n/a.
module tb_sram_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        ready;
    logic        ram_en, ram_r_wb;
    logic [10:0] ram_ad;
    logic [31:0] ram_ben, ram_di, ram_do;
    logic [4:0]  ram_tst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_wb_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .ready_o    (ready),
        .ram_en     (ram_en),
        .ram_r_wb   (ram_r_wb),
        .ram_ad     (ram_ad),
        .ram_ben    (ram_ben),
        .ram_di     (ram_di),
        .ram_do     (ram_do),
        .ram_tst    (ram_tst)
    );

    // Behavioural macro: samples pins on the rising edge, read data the cycle after.
    logic [31:0] mem [0:2047];
    logic [31:0] do_q;
    logic        prefill;

    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (ram_en) begin
            if (!ram_r_wb) mem[ram_ad] <= (mem[ram_ad] & ~ram_ben) | (ram_di & ram_ben);
            else           do_q <= mem[ram_ad];
        end
    end
    assign ram_do = do_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: one entry per expected ack; reads carry the expected data.
    typedef struct packed {
        logic        is_rd;
        logic [31:0] dat;
    } exp_t;
    exp_t sb_q[$];

    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (ack) begin
            if (prev_ack) chk("ack_single_cycle", 32'(prev_ack), 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_rd) chk("read_data", rdat, e.dat);
            end
        end
        prev_ack = ack;
    end

    // Pin snapshot taken in the first cycle of a request, plus ack-time status.
    logic        p_en, p_rwb, a_ready;
    logic [10:0] p_ad;
    logic [31:0] p_ben;

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] exp_rd, output int lat);
        exp_t e;
        e.is_rd = ~w;
        e.dat   = exp_rd;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        @(negedge clk);
        p_en = ram_en; p_rwb = ram_r_wb; p_ad = ram_ad; p_ben = ram_ben;
        lat = 0;
        while (!ack && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        a_ready = ready;
        if (!ack) chk("ack_timeout", 32'(lat), 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        int lat, errs, bad;
        rst_n = 1'b0; prefill = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1 prefill = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_r_wb", 32'(ram_r_wb), 32'd1);
        chk("rst_ram_ben", ram_ben, 32'd0);
        chk("rst_ram_tst", 32'(ram_tst), 32'd0);

        // Clear sweep: 2048 consecutive full-mask writes of 0, then ready.
        @(posedge clk); #1 rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (!ram_en || ram_r_wb || ram_ad != 11'(i) || ram_ben != 32'hFFFF_FFFF ||
                ram_di != 32'd0 || ready) errs++;
        end
        chk("sweep_cycles", 32'(errs), 32'd0);
        @(negedge clk);
        chk("ready_after_sweep", 32'(ready), 32'd1);
        chk("en_after_sweep", 32'(ram_en), 32'd0);
        errs = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] != 32'd0) errs++;
        chk("mem_cleared", 32'(errs), 32'd0);

        // Full-word write then read at word 4.
        wb_xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, lat);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_en", 32'(p_en), 32'd1);
        chk("wr_rwb", 32'(p_rwb), 32'd0);
        chk("wr_ad", 32'(p_ad), 32'd4);
        chk("wr_ben", p_ben, 32'hFFFF_FFFF);
        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, lat);
        chk("rd_lat", 32'(lat), 32'd1);
        chk("rd_rwb", 32'(p_rwb), 32'd1);
        chk("rd_ben", p_ben, 32'd0);
        chk("held_after_rd", rdat, 32'hDEAD_BEEF);

        // Misaligned byte address still hits word 4.
        wb_xfer(1'b0, 32'h3000_0013, 4'hF, 32'h0, 32'hDEAD_BEEF, lat);
        chk("misaligned_ad", 32'(p_ad), 32'd4);

        // Byte-lane write, then sel=0 write that must leave memory alone.
        wb_xfer(1'b1, 32'h3000_0040, 4'hF, 32'h1122_3344, 32'h0, lat);
        wb_xfer(1'b1, 32'h3000_0040, 4'b0100, 32'h00AA_0000, 32'h0, lat);
        chk("byte_ben", p_ben, 32'h00FF_0000);
        chk("byte_ad", 32'(p_ad), 32'd16);
        wb_xfer(1'b0, 32'h3000_0040, 4'hF, 32'h0, 32'h11AA_3344, lat);
        wb_xfer(1'b1, 32'h3000_0040, 4'h0, 32'hFFFF_FFFF, 32'h0, lat);
        chk("sel0_ben", p_ben, 32'd0);
        chk("sel0_en", 32'(p_en), 32'd1);
        chk("sel0_lat", 32'(lat), 32'd1);
        wb_xfer(1'b0, 32'h3000_0040, 4'hF, 32'h0, 32'h11AA_3344, lat);

        // Out-of-window request held for 10 cycles.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_2000; wdat = 32'h5555_AAAA;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ram_en || ack) bad++;
        end
        chk("out_of_window", 32'(bad), 32'd0);
        @(posedge clk); #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;

        // Reset pulse while a read is being acked.
        sb_q.push_back('{is_rd: 1'b1, dat: 32'hDEAD_BEEF});
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0010;
        @(negedge clk);
        @(negedge clk);
        chk("ack_before_reset", 32'(ack), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1 cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("ack_drop_on_reset", 32'(ack), 32'd0);
        chk("en_in_reset", 32'(ram_en), 32'd0);
        chk("rwb_in_reset", 32'(ram_r_wb), 32'd1);
        chk("ready_in_reset", 32'(ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("sweep_restart_ad", 32'(ram_ad), 32'd0);
        chk("sweep_restart_en", 32'(ram_en), 32'd1);

        // Write held through the sweep: stalled until ready, and not overwritten.
        wb_xfer(1'b1, 32'h3000_0020, 4'hF, 32'h1234_5678, 32'h0, lat);
        chk("clear_stall", 32'(lat >= 2000), 32'd1);
        chk("ready_at_ack", 32'(a_ready), 32'd1);
        wb_xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0, 32'h1234_5678, lat);
        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'h0000_0000, lat);
        chk("rd_after_clear_lat", 32'(lat), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("ram_tst_end", 32'(ram_tst), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
